// File: rtl/lcd_ctrl.sv
// HD44780 character LCD controller, 8-bit write-only mode.
// Runs the power-on init sequence, then prints bytes from the decoder with automatic line wrapping.
module lcd_ctrl #(
    parameter int unsigned T_PWR = 1_080_000,
    parameter int unsigned T_EN  = 14,
    parameter int unsigned T_CMD = 1100,
    parameter int unsigned T_CLR = 44_000
) (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic       strt,
    input  logic [7:0] lcd_data,
    output logic       lcd_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    localparam int unsigned T_MAX_A = (T_PWR > T_CLR) ? T_PWR : T_CLR;
    localparam int unsigned T_MAX_B = (T_CMD > T_EN) ? T_CMD : T_EN;
    localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int          CW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CW-1:0] PWR_LAST = CW'(T_PWR - 1);
    localparam logic [CW-1:0] EN_LAST  = CW'(T_EN - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(T_CMD - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(T_CLR - 1);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        SETUP,
        EN_HI,
        WAIT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          line_q, line_d;
    logic [4:0]    col_q, col_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;
    logic [7:0]    db_q, db_d;
    logic          e_q, e_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          clr_q, clr_d;
    logic          data_pend_q, data_pend_d;
    logic          in_init_q, in_init_d;
    logic [1:0]    init_idx_q, init_idx_d;

    logic [7:0]    addr_cmd;
    logic [CW-1:0] wait_last;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    // DDRAM address of the start of the other line
    assign addr_cmd  = line_q ? 8'h80 : 8'hC0;
    assign wait_last = clr_q ? CLR_LAST : CMD_LAST;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        col_d       = col_q;
        byte_d      = byte_q;
        rs_d        = rs_q;
        db_d        = db_q;
        clr_d       = clr_q;
        data_pend_d = data_pend_q;
        in_init_d   = in_init_q;
        init_idx_d  = init_idx_q;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            INIT: begin
                rs_d    = 1'b0;
                db_d    = init_cmd(init_idx_q);
                clr_d   = (init_idx_q == 2'd3);
                state_d = SETUP;
            end
            IDLE: begin
                if (strt) begin
                    byte_d      = lcd_data;
                    state_d     = SETUP;
                    data_pend_d = 1'b0;
                    clr_d       = 1'b0;
                    rs_d        = 1'b0;
                    if (lcd_data == 8'h0A) begin
                        db_d   = addr_cmd;
                        line_d = ~line_q;
                        col_d  = 5'd0;
                    end else if (lcd_data == 8'h0C) begin
                        db_d   = 8'h01;
                        clr_d  = 1'b1;
                        line_d = 1'b0;
                        col_d  = 5'd0;
                    end else if (col_q == 5'd16) begin
                        // Wrap: address command first, the character follows after its wait
                        db_d        = addr_cmd;
                        line_d      = ~line_q;
                        col_d       = 5'd1;
                        data_pend_d = 1'b1;
                    end else begin
                        rs_d  = 1'b1;
                        db_d  = lcd_data;
                        col_d = col_q + 5'd1;
                    end
                end
            end
            SETUP: begin
                state_d = EN_HI;
                cnt_d   = '0;
            end
            EN_HI: begin
                if (cnt_q == EN_LAST) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    if (in_init_q) begin
                        if (init_idx_q == 2'd3) begin
                            in_init_d = 1'b0;
                            state_d   = IDLE;
                            line_d    = 1'b0;
                            col_d     = 5'd0;
                        end else begin
                            init_idx_d = init_idx_q + 2'd1;
                            state_d    = INIT;
                        end
                    end else if (data_pend_q) begin
                        data_pend_d = 1'b0;
                        rs_d        = 1'b1;
                        db_d        = byte_q;
                        clr_d       = 1'b0;
                        state_d     = SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = PWR_WAIT;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q without glitches
    always_comb begin
        e_d    = (state_d == EN_HI);
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= '0;
            line_q      <= 1'b0;
            col_q       <= 5'd0;
            byte_q      <= 8'h00;
            rs_q        <= 1'b0;
            db_q        <= 8'h00;
            e_q         <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            clr_q       <= 1'b0;
            data_pend_q <= 1'b0;
            in_init_q   <= 1'b1;
            init_idx_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            col_q       <= col_d;
            byte_q      <= byte_d;
            rs_q        <= rs_d;
            db_q        <= db_d;
            e_q         <= e_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            clr_q       <= clr_d;
            data_pend_q <= data_pend_d;
            in_init_q   <= in_init_d;
            init_idx_q  <= init_idx_d;
        end
    end

    assign lcd_done = done_q;
    assign busy     = busy_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = e_q;
    assign lcd_db   = db_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl with shortened timing (T_PWR=20, T_EN=2, T_CMD=4, T_CLR=8).
// Character requests come from a vector table; init, ignored strt and aborted transfers are hand sequences.
module tb_lcd_ctrl;

    localparam int T_EN = 2;

    logic       clk;
    logic       sys_rst;
    logic       strt;
    logic [7:0] lcd_data;
    logic       lcd_done;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;

    typedef struct {
        logic [7:0] data;
        logic       has_cmd;
        logic [7:0] cmd;
        logic       has_data;
        int         lat;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] xq[$];
    int         n_checks;
    int         n_fail;
    int         done_count;
    logic       e_prev;
    int         e_width;

    lcd_ctrl #(
        .T_PWR(20),
        .T_EN (2),
        .T_CMD(4),
        .T_CLR(8)
    ) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .strt    (strt),
        .lcd_data(lcd_data),
        .lcd_done(lcd_done),
        .busy    (busy),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_e   (lcd_e),
        .lcd_db  (lcd_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Records every enable pulse as {rs, db} and checks its width and that rs/db stay put
    always @(negedge clk) begin
        if (!sys_rst) begin
            e_prev  = 1'b0;
            e_width = 0;
        end else begin
            if (lcd_done) done_count++;
            if (lcd_e) begin
                if (!e_prev) begin
                    xq.push_back({lcd_rs, lcd_db});
                    e_width = 0;
                end
                e_width++;
            end else if (e_prev) begin
                checkOutput("e_width", e_width, T_EN);
                if (xq.size() > 0) checkOutput("rs_db_hold", {lcd_rs, lcd_db}, xq[$]);
                checkOutput("rw_low", lcd_rw, 0);
            end
            e_prev = lcd_e;
        end
    end

    function automatic vec_t mkVec(input logic [7:0] d, input logic hc, input logic [7:0] c,
                                   input logic hd, input int l);
        vec_t v;
        v.data     = d;
        v.has_cmd  = hc;
        v.cmd      = c;
        v.has_data = hd;
        v.lat      = l;
        return v;
    endfunction

    task automatic waitIdle();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (busy) checkOutput("idle_timeout", 1, 0);
    endtask

    // Drives one strt pulse; lat is the cycle index (1 = cycle after the sampling edge) of lcd_done
    task automatic applyStimulus(input logic [7:0] d, output int lat);
        @(negedge clk);
        strt     = 1'b1;
        lcd_data = d;
        lat      = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            strt = 1'b0;
            if (lcd_done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic runVector(input vec_t v);
        int lat;
        int d0;
        int nexp;
        waitIdle();
        xq.delete();
        d0 = done_count;
        applyStimulus(v.data, lat);
        checkOutput($sformatf("latency[%02h]", v.data), lat, v.lat);
        nexp = int'(v.has_cmd) + int'(v.has_data);
        checkOutput($sformatf("xfer_count[%02h]", v.data), xq.size(), nexp);
        if (xq.size() == nexp) begin
            if (v.has_cmd) checkOutput($sformatf("cmd_xfer[%02h]", v.data), xq[0], {1'b0, v.cmd});
            if (v.has_data) checkOutput($sformatf("data_xfer[%02h]", v.data), xq[nexp-1], {1'b1, v.data});
        end
        @(negedge clk);
        checkOutput("busy_done_after", {busy, lcd_done}, 0);
        checkOutput("done_pulses", done_count - d0, 1);
    endtask

    // Call right after releasing reset on a falling edge
    task automatic checkInit();
        int first_e;
        int first_idle;
        int d0;
        xq.delete();
        d0         = done_count;
        first_e    = -1;
        first_idle = -1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (first_e < 0 && lcd_e) first_e = n;
            if (!busy) begin
                first_idle = n;
                break;
            end
        end
        checkOutput("init_first_e", first_e, 22);
        checkOutput("init_busy_fall", first_idle, 56);
        checkOutput("init_xfer_count", xq.size(), 4);
        if (xq.size() == 4) begin
            checkOutput("init_cmd0", xq[0], 9'h038);
            checkOutput("init_cmd1", xq[1], 9'h00C);
            checkOutput("init_cmd2", xq[2], 9'h006);
            checkOutput("init_cmd3", xq[3], 9'h001);
        end
        checkOutput("init_no_done", done_count - d0, 0);
    endtask

    // Starts a print request and pulls reset low in the given cycle of the transfer
    task automatic abortRequest(input int at_cycle, input int exp_e);
        int d0;
        waitIdle();
        d0 = done_count;
        @(negedge clk);
        strt     = 1'b1;
        lcd_data = 8'h46;
        for (int n = 1; n <= at_cycle; n++) begin
            @(negedge clk);
            strt = 1'b0;
        end
        checkOutput($sformatf("e_before_abort[%0d]", at_cycle), lcd_e, exp_e);
        #1 sys_rst = 1'b0;
        #1;
        checkOutput("e_async_drop", lcd_e, 0);
        checkOutput("busy_in_reset", busy, 1);
        repeat (3) @(negedge clk);
        checkOutput("no_done_on_abort", done_count - d0, 0);
        sys_rst = 1'b1;
        checkInit();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int d0;
        n_checks   = 0;
        n_fail     = 0;
        done_count = 0;
        sys_rst    = 1'b0;
        strt       = 1'b0;
        lcd_data   = 8'h00;

        for (int i = 0; i < 16; i++) vecs.push_back(mkVec(8'h41 + 8'(i), 1'b0, 8'h00, 1'b1, 8));
        vecs.push_back(mkVec(8'h5A, 1'b1, 8'hC0, 1'b1, 15));
        for (int i = 0; i < 15; i++) vecs.push_back(mkVec(8'h61 + 8'(i), 1'b0, 8'h00, 1'b1, 8));
        vecs.push_back(mkVec(8'h5A, 1'b1, 8'h80, 1'b1, 15));
        vecs.push_back(mkVec(8'h0A, 1'b1, 8'hC0, 1'b0, 8));
        vecs.push_back(mkVec(8'h0C, 1'b1, 8'h01, 1'b0, 12));
        vecs.push_back(mkVec(8'h42, 1'b0, 8'h00, 1'b1, 8));

        repeat (3) @(negedge clk);
        checkOutput("rst_lcd_e", lcd_e, 0);
        checkOutput("rst_lcd_rs", lcd_rs, 0);
        checkOutput("rst_lcd_rw", lcd_rw, 0);
        checkOutput("rst_lcd_db", lcd_db, 0);
        checkOutput("rst_lcd_done", lcd_done, 0);
        checkOutput("rst_busy", busy, 1);
        sys_rst = 1'b1;
        checkInit();

        foreach (vecs[i]) runVector(vecs[i]);

        // A second strt while the enable is high must be dropped, not queued
        waitIdle();
        xq.delete();
        d0 = done_count;
        @(negedge clk);
        strt     = 1'b1;
        lcd_data = 8'h43;
        @(negedge clk);
        strt = 1'b0;
        @(negedge clk);
        checkOutput("busy_strt_en_hi", lcd_e, 1);
        strt     = 1'b1;
        lcd_data = 8'h44;
        @(negedge clk);
        strt = 1'b0;
        lat  = -1;
        for (int n = 4; n <= 100; n++) begin
            @(negedge clk);
            if (lcd_done) begin
                lat = n;
                break;
            end
        end
        checkOutput("busy_strt_latency", lat, 8);
        repeat (20) @(negedge clk);
        checkOutput("busy_strt_done_count", done_count - d0, 1);
        checkOutput("busy_strt_xfer_count", xq.size(), 1);
        if (xq.size() == 1) checkOutput("busy_strt_xfer", xq[0], 9'h143);

        abortRequest(2, 1);
        abortRequest(5, 0);

        runVector(mkVec(8'h47, 1'b0, 8'h00, 1'b1, 8));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
